// File: rtl/fir_pkg.sv
// Shared widths, default low-pass coefficients and FSM encoding for the
// single-multiplier serial FIR.
package fir_pkg;

  localparam int FIR_NTAPS  = 16;
  localparam int FIR_DATA_W = 14;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_OUT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } fir_state_e;

  // Symmetric low-pass, Q1.15; index 0 weights the newest sample.
  localparam logic signed [FIR_COEF_W-1:0] LPF_COEFS [FIR_NTAPS] = '{
    -16'sd120, -16'sd200, 16'sd0,    16'sd700,  16'sd1800, 16'sd3200, 16'sd4400, 16'sd5100,
    16'sd5100, 16'sd4400, 16'sd3200, 16'sd1800, 16'sd700,  16'sd0,    -16'sd200, -16'sd120
  };

  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_serial_mac_round_sat.sv
// Combinational round-half-up (arithmetic shift) and saturation from the
// accumulator width down to the output width.
module round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = acc_w(FIR_DATA_W, FIR_COEF_W, FIR_NTAPS),
  parameter int OUT_W = FIR_OUT_W,
  parameter int SHIFT = FIR_COEF_W - 1
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int EW = ACC_W + 1;
  localparam logic signed [EW-1:0] HALF  = EW'(1) <<< (SHIFT - 1);
  localparam logic signed [EW-1:0] MAX_S = (EW'(1) <<< (OUT_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MIN_S = ~MAX_S;

  logic signed [EW-1:0] sum_s;
  logic signed [EW-1:0] shr_s;

  assign sum_s = EW'(acc) + HALF;
  assign shr_s = sum_s >>> SHIFT;

  // Clamp the shifted value into the signed output range.
  always_comb begin
    res = '0;
    if (shr_s > MAX_S) begin
      res = MAX_S[OUT_W-1:0];
    end else if (shr_s < MIN_S) begin
      res = MIN_S[OUT_W-1:0];
    end else begin
      res = shr_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one sample per handshake, NTAPS serial MAC cycles,
// then a round/saturate cycle producing a one-cycle o_valid strobe.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int OUT_W  = FIR_OUT_W,
  parameter logic signed [COEF_W-1:0] COEFS [NTAPS] = LPF_COEFS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [OUT_W-1:0]  o_data,
  output logic                     o_valid,
  output logic                     o_overrun
);

  localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
  localparam int PRD_W = DATA_W + COEF_W;
  localparam int K_W   = $clog2(NTAPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(NTAPS - 1);

  fir_state_e               state_r, state_s;
  logic signed [DATA_W-1:0] dly_r [NTAPS];
  logic signed [ACC_W-1:0]  acc_r;
  logic [K_W-1:0]           k_r;
  logic                     ready_r, valid_r, overrun_r, accept_s;
  logic signed [OUT_W-1:0]  data_r, rnd_s;
  logic signed [PRD_W-1:0]  prod_s;

  assign accept_s = i_valid & ready_r;
  assign prod_s   = PRD_W'(dly_r[k_r]) * PRD_W'(COEFS[k_r]);

  round_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(COEF_W - 1)) u_round_sat (
    .acc (acc_r),
    .res (rnd_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_s = ST_MAC; else state_s = ST_IDLE;
      ST_MAC:   if (k_r == K_LAST) state_s = ST_ROUND; else state_s = ST_MAC;
      ST_ROUND: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Delay line, accumulator and tap index; an overrun never reaches here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) dly_r[i] <= '0;
      acc_r <= '0;
      k_r   <= '0;
    end else if (accept_s) begin
      for (int i = NTAPS - 1; i > 0; i--) dly_r[i] <= dly_r[i-1];
      dly_r[0] <= i_sample;
      acc_r    <= '0;
      k_r      <= '0;
    end else if (state_r == ST_MAC) begin
      acc_r <= acc_r + ACC_W'(prod_s);
      k_r   <= k_r + K_W'(1);
    end else begin
      acc_r <= acc_r;
      k_r   <= k_r;
    end
  end

  // Registered handshake, held result and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      data_r    <= '0;
      overrun_r <= 1'b0;
    end else begin
      ready_r <= (state_s == ST_IDLE);
      valid_r <= (state_r == ST_ROUND);
      if (state_r == ST_ROUND) data_r <= rnd_s;
      else                     data_r <= data_r;
      if (i_valid && !ready_r) overrun_r <= 1'b1;
      else                     overrun_r <= overrun_r;
    end
  end

  assign o_ready   = ready_r;
  assign o_data    = data_r;
  assign o_valid   = valid_r;
  assign o_overrun = overrun_r;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomised self-checking bench for fir_serial_mac: four instances with
// different coefficient sets, checked against an arithmetic FIR model.
module tb_fir_serial_mac;
  import fir_pkg::*;

  localparam logic signed [15:0] C_DC  [16] = '{default: 16'sh0800};
  localparam logic signed [15:0] C_RND [16] = '{0: 16'sh4000, default: 16'sh0000};
  localparam logic signed [15:0] C_SAT [16] = '{default: 16'sh7FFF};

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic signed [13:0] smp [4];
  logic [3:0]        vin = 4'b0000;
  logic [3:0]        rdy, vout, ovr;
  logic signed [15:0] dout [4];

  int n_cmp  = 0;
  int n_fail = 0;
  int hist [4][16];
  int coef [4][16];

  always #5 clk = ~clk;

  fir_serial_mac u_lpf (.clk(clk), .rst_n(rst_n), .i_sample(smp[0]), .i_valid(vin[0]),
    .o_ready(rdy[0]), .o_data(dout[0]), .o_valid(vout[0]), .o_overrun(ovr[0]));
  fir_serial_mac #(.COEFS(C_DC)) u_dc (.clk(clk), .rst_n(rst_n), .i_sample(smp[1]), .i_valid(vin[1]),
    .o_ready(rdy[1]), .o_data(dout[1]), .o_valid(vout[1]), .o_overrun(ovr[1]));
  fir_serial_mac #(.COEFS(C_RND)) u_rnd (.clk(clk), .rst_n(rst_n), .i_sample(smp[2]), .i_valid(vin[2]),
    .o_ready(rdy[2]), .o_data(dout[2]), .o_valid(vout[2]), .o_overrun(ovr[2]));
  fir_serial_mac #(.COEFS(C_SAT)) u_sat (.clk(clk), .rst_n(rst_n), .i_sample(smp[3]), .i_valid(vin[3]),
    .o_ready(rdy[3]), .o_data(dout[3]), .o_valid(vout[3]), .o_overrun(ovr[3]));

  function automatic void model_clear();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 16; i++) hist[f][i] = 0;
  endfunction

  function automatic void model_push(input int f, input int s);
    for (int i = 15; i > 0; i--) hist[f][i] = hist[f][i-1];
    hist[f][0] = s;
  endfunction

  // y = clamp(floor((sum + 2^14) / 2^15)) over the last 16 accepted samples.
  function automatic int model_out(input int f);
    longint acc, num, q;
    acc = 0;
    for (int i = 0; i < 16; i++) acc += longint'(hist[f][i]) * longint'(coef[f][i]);
    num = acc + 64'sd16384;
    q = num / 64'sd32768;
    if ((num % 64'sd32768) != 0 && num < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic accept(input int f, input logic signed [13:0] s);
    @(negedge clk);
    smp[f] = s;
    vin[f] = 1'b1;
    model_push(f, int'(s));
    @(posedge clk);
    #1 vin[f] = 1'b0;
  endtask

  task automatic push_and_wait(input int f, input logic signed [13:0] s,
                               output logic signed [15:0] got, output bit tmo);
    accept(f, s);
    tmo = 1'b1;
    got = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (vout[f] === 1'b1) begin
        got = dout[f];
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) smp[i] = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, rdy[i]); end
      n_cmp++; if (vout[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, vout[i]); end
      n_cmp++; if (dout[i] !== 16'sd0) begin n_fail++; $display("FAIL reset_data[%0d]: got %0d expected 0", i, dout[i]); end
      n_cmp++; if (ovr[i] !== 1'b0) begin n_fail++; $display("FAIL reset_overrun[%0d]: got %b expected 0", i, ovr[i]); end
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_dc_gain();
    logic signed [15:0] got; bit tmo; int e;
    for (int n = 1; n <= 16; n++) begin
      push_and_wait(1, 14'sd8191, got, tmo);
      e = model_out(1);
      n_cmp++; if (tmo || got !== 16'(e)) begin n_fail++; $display("FAIL dc_out%0d: got %0d expected %0d tmo=%0d", n, got, e, tmo); end
    end
    n_cmp++; if (got !== 16'sd8191) begin n_fail++; $display("FAIL dc_final: got %0d expected 8191", got); end
  endtask

  task automatic test_latency();
    logic signed [13:0] s1, s2; int e1, e2; int bad_r, bad_v;
    bad_r = 0; bad_v = 0;
    s1 = 14'($urandom()); s2 = 14'($urandom());
    accept(0, s1);
    e1 = model_out(0);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (rdy[0] !== 1'b0) bad_r++;
      if (vout[0] !== 1'b0) bad_v++;
    end
    n_cmp++; if (bad_r != 0) begin n_fail++; $display("FAIL lat_ready_low: got %0d high cycles expected 0", bad_r); end
    n_cmp++; if (bad_v != 0) begin n_fail++; $display("FAIL lat_early_valid: got %0d valid cycles expected 0", bad_v); end
    @(negedge clk);
    n_cmp++; if (vout[0] !== 1'b1) begin n_fail++; $display("FAIL lat_valid18: got %b expected 1", vout[0]); end
    n_cmp++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL lat_ready18: got %b expected 1", rdy[0]); end
    n_cmp++; if (dout[0] !== 16'(e1)) begin n_fail++; $display("FAIL lat_data1: got %0d expected %0d", dout[0], e1); end
    smp[0] = s2; vin[0] = 1'b1;
    model_push(0, int'(s2));
    e2 = model_out(0);
    @(posedge clk);
    #1 vin[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (vout[0] !== 1'b0) begin n_fail++; $display("FAIL lat_valid_width: got %b expected 0", vout[0]); end
    bad_v = 0;
    for (int m = 2; m <= 17; m++) begin
      @(negedge clk);
      if (vout[0] !== 1'b0) bad_v++;
    end
    @(negedge clk);
    n_cmp++; if (bad_v != 0 || vout[0] !== 1'b1) begin n_fail++; $display("FAIL lat_valid36: got %b early=%0d expected 1", vout[0], bad_v); end
    n_cmp++; if (dout[0] !== 16'(e2)) begin n_fail++; $display("FAIL lat_data2: got %0d expected %0d", dout[0], e2); end
  endtask

  task automatic test_rounding();
    logic signed [15:0] got; bit tmo; logic signed [13:0] s; int e;
    push_and_wait(2, 14'sd3, got, tmo);
    n_cmp++; if (tmo || got !== 16'sd2) begin n_fail++; $display("FAIL round_p3: got %0d expected 2", got); end
    push_and_wait(2, -14'sd3, got, tmo);
    n_cmp++; if (tmo || got !== -16'sd1) begin n_fail++; $display("FAIL round_m3: got %0d expected -1", got); end
    push_and_wait(2, 14'sd1, got, tmo);
    n_cmp++; if (tmo || got !== 16'sd1) begin n_fail++; $display("FAIL round_p1: got %0d expected 1", got); end
    for (int n = 0; n < 6; n++) begin
      s = 14'($urandom());
      push_and_wait(2, s, got, tmo);
      e = model_out(2);
      n_cmp++; if (tmo || got !== 16'(e)) begin n_fail++; $display("FAIL round_rand%0d: in %0d got %0d expected %0d", n, s, got, e); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] got; bit tmo; int e;
    for (int n = 0; n < 16; n++) begin
      push_and_wait(3, 14'sd8191, got, tmo);
      e = model_out(3);
      n_cmp++; if (tmo || got !== 16'(e)) begin n_fail++; $display("FAIL sat_pos%0d: got %0d expected %0d", n, got, e); end
    end
    n_cmp++; if (got !== 16'sd32767) begin n_fail++; $display("FAIL sat_max: got %0d expected 32767", got); end
    for (int n = 0; n < 16; n++) begin
      push_and_wait(3, -14'sd8192, got, tmo);
      e = model_out(3);
      n_cmp++; if (tmo || got !== 16'(e)) begin n_fail++; $display("FAIL sat_neg%0d: got %0d expected %0d", n, got, e); end
    end
    n_cmp++; if (got !== -16'sd32768) begin n_fail++; $display("FAIL sat_min: got %0d expected -32768", got); end
  endtask

  task automatic test_random();
    logic signed [15:0] got; bit tmo; logic signed [13:0] s; int e;
    for (int n = 0; n < 12; n++) begin
      s = 14'($urandom());
      push_and_wait(0, s, got, tmo);
      e = model_out(0);
      n_cmp++; if (tmo || got !== 16'(e)) begin n_fail++; $display("FAIL lpf_rand%0d: in %0d got %0d expected %0d", n, s, got, e); end
    end
  endtask

  task automatic test_overrun();
    logic signed [15:0] got, d1; bit tmo, seen; logic signed [13:0] s; int e;
    seen = 1'b0; d1 = '0;
    s = 14'($urandom());
    accept(0, s);
    e = model_out(0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 5) begin
        n_cmp++; if (ovr[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b expected 0", ovr[0]); end
        smp[0] = 14'($urandom()); vin[0] = 1'b1;
      end
      if (n == 6) begin
        vin[0] = 1'b0;
        n_cmp++; if (ovr[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ovr[0]); end
      end
      if (vout[0] === 1'b1 && !seen) begin seen = 1'b1; d1 = dout[0]; end
    end
    n_cmp++; if (!seen || d1 !== 16'(e)) begin n_fail++; $display("FAIL ovr_result: got %0d expected %0d seen=%0d", d1, e, seen); end
    s = 14'($urandom());
    push_and_wait(0, s, got, tmo);
    e = model_out(0);
    n_cmp++; if (tmo || got !== 16'(e)) begin n_fail++; $display("FAIL ovr_history: got %0d expected %0d", got, e); end
    n_cmp++; if (ovr[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", ovr[0]); end
  endtask

  task automatic test_reset_mid_mac();
    logic signed [15:0] got; bit tmo; int e, late;
    late = 0;
    accept(0, 14'($urandom()));
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", rdy[0]); end
    n_cmp++; if (dout[0] !== 16'sd0) begin n_fail++; $display("FAIL rst_mid_data: got %0d expected 0", dout[0]); end
    n_cmp++; if (ovr[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun: got %b expected 0", ovr[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vout[0] !== 1'b0) late++;
    end
    n_cmp++; if (late != 0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %0d valid cycles expected 0", late); end
    for (int n = 0; n < 16; n++) begin
      push_and_wait(0, (n == 0) ? 14'sd8191 : 14'sd0, got, tmo);
      e = model_out(0);
      n_cmp++; if (tmo || got !== 16'(e)) begin n_fail++; $display("FAIL impulse%0d: got %0d expected %0d", n, got, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      coef[0][i] = int'(LPF_COEFS[i]);
      coef[1][i] = 2048;
      coef[2][i] = (i == 0) ? 16384 : 0;
      coef[3][i] = 32767;
    end
    model_clear();
    test_reset();
    test_dc_gain();
    test_latency();
    test_rounding();
    test_saturation();
    test_random();
    test_overrun();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
